mmio_data_memory: RTL and testbench

//  Parametrised data-memory subsystem for the rv32i core: word RAM plus IO register bank plus UART TX FIFO.

---
 rtl/mmio_data_memory_if.sv | 29 ++
 rtl/mmio_data_memory.sv | 115 +++++++++++
 tb/tb_mmio_data_memory.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/mmio_data_memory_if.sv
// rtl/mmio_data_memory_if.sv - load/store, IO debug and UART stream signals of the data memory
interface mmio_data_memory_if #(
  parameter int ADDR_W = 14
);
  logic              wen;
  logic              ren;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic [31:0]       rdata;
  logic              rvalid;
  logic [7:0]        io_addr;
  logic [31:0]       io_data;
  logic [7:0]        uart_data;
  logic              uart_valid;
  logic              uart_ready;
  logic              uart_ovf;

  modport master (
    output wen, ren, waddr, raddr, wdata, wstrb, io_addr, uart_ready,
    input  rdata, rvalid, io_data, uart_data, uart_valid, uart_ovf
  );

  modport slave (
    input  wen, ren, waddr, raddr, wdata, wstrb, io_addr, uart_ready,
    output rdata, rvalid, io_data, uart_data, uart_valid, uart_ovf
  );
endinterface

// File: rtl/mmio_data_memory.sv
// rtl/mmio_data_memory.sv - word RAM, IO register bank and UART TX FIFO behind one load/store port
// Top two address bits pick RAM (0x), IO (10) or UART (11); reads are registered and read-first.
module mmio_data_memory #(
  parameter int ADDR_W     = 14,
  parameter int RAM_AW     = 12,
  parameter int IO_REGS    = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic               clk,
  input logic               rst,
  mmio_data_memory_if.slave bus
);
  localparam int IO_AW = (IO_REGS > 1) ? $clog2(IO_REGS) : 1;
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int OFF_W = ADDR_W - 2;

  logic [31:0] ram [2**RAM_AW];
  logic [31:0] io_regs [IO_REGS];
  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          ovf;
  logic [31:0]   rdata_r, rd_mux, status;
  logic          rvalid_r;

  logic [1:0]       w_reg, r_reg;
  logic [OFF_W-1:0] w_off, r_off;
  logic             w_ram, w_io, data_wr, ctrl_wr;
  logic             empty, full, pop, push_ok, ovf_set;
  logic             unused_ok;

  assign w_reg = bus.waddr[ADDR_W-1 -: 2];
  assign r_reg = bus.raddr[ADDR_W-1 -: 2];
  assign w_off = bus.waddr[OFF_W-1:0];
  assign r_off = bus.raddr[OFF_W-1:0];

  // Strobes are masked while rst is high so nothing lands during reset.
  assign w_ram   = !rst && bus.wen && !w_reg[1];
  assign w_io    = !rst && bus.wen && (w_reg == 2'b10);
  assign data_wr = !rst && bus.wen && (w_reg == 2'b11) && (w_off == OFF_W'(0));
  assign ctrl_wr = !rst && bus.wen && (w_reg == 2'b11) && (w_off == OFF_W'(1));

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(FIFO_DEPTH));
  assign pop     = !empty && bus.uart_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok = data_wr && (!full || pop);
  assign ovf_set = data_wr && full && !pop;
  assign status  = {16'b0, 8'(count), 5'b0, ovf, full, empty};

  always_ff @(posedge clk) begin
    if (w_ram) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) ram[bus.waddr[RAM_AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_regs <= '{default: '0};
    end else if (w_io) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) io_regs[bus.waddr[IO_AW-1:0]][8*b +: 8] <= bus.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= bus.wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      if (ovf_set)                       ovf <= 1'b1;
      else if (ctrl_wr && bus.wdata[0])  ovf <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (r_reg)
      2'b10:   rd_mux = io_regs[bus.raddr[IO_AW-1:0]];
      2'b11:   if (r_off == OFF_W'(1)) rd_mux = status;
      default: rd_mux = ram[bus.raddr[RAM_AW-1:0]];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= bus.ren;
      if (bus.ren) rdata_r <= rd_mux;
    end
  end

  assign bus.rdata      = rdata_r;
  assign bus.rvalid     = rvalid_r;
  assign bus.io_data    = io_regs[bus.io_addr[IO_AW-1:0]];
  assign bus.uart_data  = fifo_mem[rd_ptr];
  assign bus.uart_valid = !empty;
  assign bus.uart_ovf   = ovf;
  assign unused_ok      = ^bus.io_addr;
endmodule

// File: tb/tb_mmio_data_memory.sv
// tb/tb_mmio_data_memory.sv - scoreboard bench for mmio_data_memory against a queue/array reference model
module tb_mmio_data_memory;
  localparam int ADDR_W = 14, RAM_AW = 12, IO_REGS = 8, FIFO_DEPTH = 16;

  typedef struct {
    bit          v;
    logic [31:0] d;
  } rd_t;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;
  bit   comb_chk = 1'b0;

  logic [31:0] ram_m [int];
  logic [31:0] io_m [IO_REGS];
  logic [7:0]  fq [$];
  bit          ovf_m;
  logic [31:0] rdata_m;
  rd_t         rd_q [$];
  logic [11:0] pool [8];

  mmio_data_memory_if #(.ADDR_W(ADDR_W)) bus ();

  mmio_data_memory #(
    .ADDR_W(ADDR_W), .RAM_AW(RAM_AW), .IO_REGS(IO_REGS), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
  endtask

  function automatic logic [31:0] model_read(input logic [13:0] a);
    logic [31:0] r;
    r = '0;
    if (!a[13]) r = ram_m.exists(int'(a[11:0])) ? ram_m[int'(a[11:0])] : 'x;
    else if (!a[12]) r = io_m[int'(a) % IO_REGS];
    else if (a[11:0] == 12'd1)
      r = {16'b0, 8'(fq.size()), 5'b0, ovf_m, fq.size() == FIFO_DEPTH, fq.size() == 0};
    return r;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] ws);
    logic [31:0] n;
    n = old;
    for (int b = 0; b < 4; b++) if (ws[b]) n[8*b +: 8] = wd[8*b +: 8];
    return n;
  endfunction

  // One bus cycle: drive at negedge, check combinational outputs, then advance the model.
  task automatic cycle(input bit r, input bit we, input logic [13:0] wa, input logic [31:0] wd,
                       input logic [3:0] ws, input bit re, input logic [13:0] ra, input bit rdy,
                       input logic [7:0] ioa);
    rd_t e;
    bit  pop, push_req, acc;
    int  idx;
    @(negedge clk);
    rst = r; bus.wen = we; bus.waddr = wa; bus.wdata = wd; bus.wstrb = ws;
    bus.ren = re; bus.raddr = ra; bus.uart_ready = rdy; bus.io_addr = ioa;
    #1;
    if (comb_chk) begin
      check("io_data", bus.io_data, io_m[int'(ioa) % IO_REGS]);
      check("uart_valid", bus.uart_valid, fq.size() != 0);
      check("uart_ovf", bus.uart_ovf, ovf_m);
      if (fq.size() != 0) check("uart_data", bus.uart_data, fq[0]);
    end
    if (r) begin
      e.v = 1'b0; e.d = '0; rdata_m = '0;
      fq.delete(); ovf_m = 1'b0;
      foreach (io_m[i]) io_m[i] = '0;
    end else begin
      if (re) begin e.v = 1'b1; e.d = model_read(ra); rdata_m = e.d; end
      else    begin e.v = 1'b0; e.d = rdata_m; end
      pop      = (fq.size() != 0) && rdy;
      push_req = we && (wa[13:12] == 2'b11) && (wa[11:0] == 12'd0);
      acc      = push_req && (fq.size() < FIFO_DEPTH || pop);
      if (pop) void'(fq.pop_front());
      if (acc) fq.push_back(wd[7:0]);
      if (we && !wa[13]) begin
        idx = int'(wa[11:0]);
        ram_m[idx] = merge(ram_m.exists(idx) ? ram_m[idx] : 'x, wd, ws);
      end
      if (we && wa[13:12] == 2'b10) io_m[int'(wa) % IO_REGS] = merge(io_m[int'(wa) % IO_REGS], wd, ws);
      if (push_req && !acc) ovf_m = 1'b1;
      else if (we && wa == 14'h3001 && wd[0]) ovf_m = 1'b0;
    end
    rd_q.push_back(e);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d, input logic [3:0] s, input bit rdy);
    cycle(0, 1, a, d, s, 0, '0, rdy, 8'd3);
  endtask

  task automatic rd(input logic [13:0] a);
    cycle(0, 0, '0, '0, '0, 1, a, 0, 8'd3);
  endtask

  task automatic rd_expect(input string name, input logic [13:0] a, input logic [31:0] exp);
    rd(a);
    @(posedge clk); #2;
    check(name, bus.rdata, exp);
    check({name, "_rvalid"}, bus.rvalid, 1'b1);
  endtask

  always @(posedge clk) begin : monitor
    rd_t e;
    #1;
    if (rd_q.size() != 0) begin
      e = rd_q.pop_front();
      check("rvalid", bus.rvalid, e.v);
      if (e.d !== 'x) check("rdata", bus.rdata, e.d);
    end
  end

  function automatic logic [13:0] rand_addr();
    case ($urandom % 7)
      0, 1:    return {1'b0, 1'($urandom), pool[$urandom % 8]};
      2:       return {2'b10, 12'($urandom)};
      3, 4:    return 14'h3000;
      5:       return 14'h3001;
      default: return {2'b11, 12'($urandom)};
    endcase
  endfunction

  initial begin
    rst = 1'b1;
    bus.wen = 0; bus.ren = 0; bus.waddr = '0; bus.raddr = '0; bus.wdata = '0;
    bus.wstrb = '0; bus.uart_ready = 0; bus.io_addr = '0;
    rdata_m = '0; ovf_m = 1'b0;
    foreach (io_m[i]) io_m[i] = '0;

    cycle(1, 0, '0, '0, '0, 0, '0, 0, 8'd0);
    comb_chk = 1'b1;
    cycle(1, 0, '0, '0, '0, 0, '0, 0, 8'd0);
    check("reset_rvalid", bus.rvalid, 1'b0);
    check("reset_rdata", bus.rdata, 32'h0);
    check("reset_uart_valid", bus.uart_valid, 1'b0);

    wr(14'h0010, 32'h0, 4'hF, 0);
    wr(14'h0010, 32'hDEADBEEF, 4'b0101, 0);
    rd_expect("ram_byte_strobe", 14'h0010, 32'h00AD00EF);
    wr(14'h0010, 32'h11111111, 4'b0000, 0);
    rd_expect("ram_strobe_zero", 14'h0010, 32'h00AD00EF);

    wr(14'h2003, 32'h00001234, 4'hF, 0);
    @(posedge clk); #2;
    check("io_data_after_write", bus.io_data, 32'h00001234);
    rd_expect("io_read", 14'h2003, 32'h00001234);

    for (int i = 0; i < 16; i++) wr(14'h3000, 32'(8'h40 + i), 4'h0, 0);
    rd_expect("status_full", 14'h3001, 32'h00001002);
    wr(14'h3000, 32'h000000EE, 4'hF, 0);
    rd_expect("status_ovf", 14'h3001, 32'h00001006);
    wr(14'h3001, 32'h00000001, 4'hF, 0);
    rd_expect("status_ovf_cleared", 14'h3001, 32'h00001002);
    wr(14'h3000, 32'h000000AA, 4'hF, 1);
    rd_expect("status_full_push_pop", 14'h3001, 32'h00001002);
    rd_expect("data_reg_reads_zero", 14'h3000, 32'h0);
    for (int i = 0; i < 16; i++) cycle(0, 0, '0, '0, '0, 0, '0, 1, 8'd3);
    rd_expect("status_drained", 14'h3001, 32'h00000001);

    wr(14'h0020, 32'd5, 4'hF, 0);
    cycle(0, 1, 14'h0020, 32'd9, 4'hF, 1, 14'h0020, 0, 8'd3);
    @(posedge clk); #2;
    check("read_first_old", bus.rdata, 32'd5);
    rd_expect("read_after_write_new", 14'h0020, 32'd9);

    for (int i = 0; i < 5; i++) wr(14'h3000, 32'(i + 1), 4'hF, 0);
    cycle(1, 1, 14'h3000, 32'h77, 4'hF, 1, 14'h2003, 0, 8'd3);
    @(posedge clk); #2;
    check("rst_uart_valid", bus.uart_valid, 1'b0);
    check("rst_io_data", bus.io_data, 32'h0);
    check("rst_rvalid", bus.rvalid, 1'b0);
    rd_expect("rst_status", 14'h3001, 32'h00000001);

    foreach (pool[i]) begin
      pool[i] = 12'($urandom);
      wr({2'b00, pool[i]}, $urandom, 4'hF, 0);
    end
    for (int blk = 0; blk < 12; blk++) begin
      int p;
      p = (blk % 3 == 0) ? 10 : (blk % 3 == 1) ? 50 : 90;
      for (int i = 0; i < 200; i++) begin
        cycle(($urandom % 400) == 0, 1'($urandom), rand_addr(), $urandom, 4'($urandom),
              1'($urandom), rand_addr(), ($urandom % 100) < p, 8'($urandom));
      end
    end

    for (int i = 0; i < 24; i++) cycle(0, 0, '0, '0, '0, 0, '0, 1, 8'($urandom));
    @(posedge clk); #3;
    check("fifo_drained", bus.uart_valid, 1'b0);
    check("scoreboard_empty", rd_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
